// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature A/B synchronizer, glitch filter and step decoder
module quad_step_decoder #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  output logic up,
  output logic down,
  output logic err
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int ICW = $clog2(FILT_LEN + 3);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(FILT_LEN + 2);

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_t;

  // Channel vectors are packed as {a, b} throughout.
  logic [1:0]     meta_q;
  logic [1:0]     sync_q;
  logic [1:0]     f_q;
  logic [1:0]     f_d;
  logic [FCW-1:0] cnt_q [2];
  logic [FCW-1:0] cnt_d [2];

  logic [1:0]     prev_q;
  state_t         state_q;
  logic [ICW-1:0] init_cnt_q;
  logic           up_q;
  logic           down_q;
  logic           err_q;

  logic           step_fwd;
  logic           step_rev;
  logic           step_jump;

  // Two-flop synchronizer per channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {a_in, b_in};
      sync_q <= meta_q;
    end
  end

  // Debounce: accept a new level only after FILT_LEN consecutive differing samples.
  always_comb begin
    f_d = f_q;
    for (int ch = 0; ch < 2; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (sync_q[ch] == f_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == FILT_LAST) begin
        f_d[ch]   = sync_q[ch];
        cnt_d[ch] = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_q      <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      f_q      <= f_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Classify the filtered transition: forward, reverse, or two-bit jump.
  always_comb begin
    step_fwd  = 1'b0;
    step_rev  = 1'b0;
    step_jump = 1'b0;
    case ({prev_q, f_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd  = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev  = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step_jump = 1'b1;
      default: ;
    endcase
  end

  // Startup/track FSM with registered strobes; INIT hides the filter settling
  // onto a nonzero idle level so no spurious step is reported after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= 2'b00;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_q <= f_q;
      case (state_q)
        ST_INIT: begin
          up_q   <= 1'b0;
          down_q <= 1'b0;
          err_q  <= 1'b0;
          if (init_cnt_q == INIT_LAST) begin
            state_q <= ST_TRACK;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        ST_TRACK: begin
          up_q   <= step_fwd;
          down_q <= step_rev;
          err_q  <= step_jump;
        end
        default: begin
          state_q <= ST_INIT;
          up_q    <= 1'b0;
          down_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign up   = up_q;
  assign down = down_q;
  assign err  = err_q;

endmodule
